pulse_stretch_explicit: RTL and testbench

Output-side counterpart to the input debouncer. Converts single-cycle event ticks (e.g. UART rx_done, tx_done, or debounced button ticks) into clean, human-visible pulses with a guaranteed minimum high time and a guaranteed minimum low gap. Ticks that arrive while a pulse is in progress are queued in a saturating pending counter. Drives LEDs or test pins on the Artix-7 board.

---
 rtl/pulse_stretch_explicit.sv | 104 ++++++++++
 tb/tb_pulse_stretch_explicit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_explicit.sv
// Stretches single-cycle ticks into 2^N-cycle pulses followed by 2^N-cycle low gaps.
// Ticks arriving mid-pulse are queued in a saturating P-bit counter; drops raise overflow.
module pulse_stretch_explicit #(
   parameter int N = 22,
   parameter int P = 4
) (
   input  logic         clk_100MHz,
   input  logic         reset,
   input  logic         tick_in,
   output logic         level_out,
   output logic         busy,
   output logic [P-1:0] pending,
   output logic         overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   localparam logic [N-1:0] Q_LOAD   = {N{1'b1}};
   localparam logic [N-1:0] Q_ONE    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [P-1:0] PEND_MAX = {P{1'b1}};
   localparam logic [P-1:0] PEND_ONE = {{(P-1){1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic [N-1:0]   q_q, q_d;
   logic [P-1:0]   pend_q, pend_d;
   logic           ovf_q, ovf_d;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      pend_d  = pend_q;
      ovf_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tick_in) begin
               state_d = S_ON;
               q_d     = Q_LOAD;
            end
         end

         S_ON: begin
            if (q_q == '0) begin
               state_d = S_OFF;
               q_d     = Q_LOAD;
            end else begin
               q_d = q_q - Q_ONE;
            end
            if (tick_in) begin
               if (pend_q == PEND_MAX) ovf_d  = 1'b1;
               else                    pend_d = pend_q + PEND_ONE;
            end
         end

         S_OFF: begin
            if (q_q == '0) begin
               // A tick on the exit cycle replaces the consumed event, so pending never overflows here.
               if ((pend_q != '0) || tick_in) begin
                  state_d = S_ON;
                  q_d     = Q_LOAD;
                  if ((pend_q != '0) && !tick_in) pend_d = pend_q - PEND_ONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               q_d = q_q - Q_ONE;
               if (tick_in) begin
                  if (pend_q == PEND_MAX) ovf_d  = 1'b1;
                  else                    pend_d = pend_q + PEND_ONE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            q_d     = '0;
         end
      endcase
   end

   assign level_out = (state_q == S_ON);
   assign busy      = (state_q != S_IDLE) || (pend_q != '0);
   assign pending   = pend_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch_explicit.sv
// Directed bench for pulse_stretch_explicit with N=4 (16/16 cycle pulses) and P=2 (3 queued).
module tb_pulse_stretch_explicit;

   localparam int N = 4;
   localparam int P = 2;

   logic         clk_100MHz = 1'b0;
   logic         reset;
   logic         tick_in;
   logic         level_out;
   logic         busy;
   logic [P-1:0] pending;
   logic         overflow;

   int n_checks = 0;
   int n_pass   = 0;

   pulse_stretch_explicit #(.N(N), .P(P)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tick_in    (tick_in),
      .level_out  (level_out),
      .busy       (busy),
      .pending    (pending),
      .overflow   (overflow)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Scenario tick schedules, by cycle number relative to the scenario start.
   function automatic bit is_tick(int s, int c);
      case (s)
         1: return c == 0;
         2: return (c == 0) || (c == 3);
         3: return c <= 4;
         4: return (c == 0) || (c == 32);
         5: return (c <= 3) || (c == 32);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int n_pulses(int s);
      case (s)
         1: return 1;
         2: return 2;
         3: return 4;
         4: return 2;
         5: return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_pend(int s, int c);
      case (s)
         2: return (c >= 4 && c <= 32) ? 1 : 0;
         3: begin
            if (c == 2) return 1;
            if (c == 3) return 2;
            if (c >= 4  && c <= 32)  return 3;
            if (c >= 33 && c <= 64)  return 2;
            if (c >= 65 && c <= 96)  return 1;
            return 0;
         end
         5: begin
            if (c == 2) return 1;
            if (c == 3) return 2;
            if (c >= 4  && c <= 64)  return 3;
            if (c >= 65 && c <= 96)  return 2;
            if (c >= 97 && c <= 128) return 1;
            return 0;
         end
         default: return 0;
      endcase
   endfunction

   task automatic run_scn(input int s);
      int last;
      int e_lvl;
      last = 32 * n_pulses(s);
      for (int c = 0; c <= last + 2; c++) begin
         tick_in = is_tick(s, c);
         e_lvl = (c >= 1 && c <= last && ((c - 1) % 32) < 16) ? 1 : 0;
         check($sformatf("s%0d c%0d level", s, c), int'(level_out), e_lvl);
         check($sformatf("s%0d c%0d busy", s, c), int'(busy), (c >= 1 && c <= last) ? 1 : 0);
         check($sformatf("s%0d c%0d pending", s, c), int'(pending), exp_pend(s, c));
         check($sformatf("s%0d c%0d overflow", s, c), int'(overflow), (s == 3 && c == 5) ? 1 : 0);
         @(posedge clk_100MHz);
         #1;
      end
      tick_in = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      tick_in = 1'b0;
      repeat (3) @(posedge clk_100MHz);
      #1;
      check("reset level", int'(level_out), 0);
      check("reset busy", int'(busy), 0);
      check("reset pending", int'(pending), 0);
      check("reset overflow", int'(overflow), 0);
      reset = 1'b0;
      @(posedge clk_100MHz);
      #1;

      for (int s = 1; s <= 5; s++) run_scn(s);

      // Asynchronous reset in the middle of a pulse with two events queued.
      for (int c = 0; c <= 8; c++) begin
         tick_in = (c <= 2);
         if (c == 3) check("s6 pending before reset", int'(pending), 2);
         if (c == 8) check("s6 level before reset", int'(level_out), 1);
         if (c < 8) begin
            @(posedge clk_100MHz);
            #1;
         end
      end
      tick_in = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("s6 reset level", int'(level_out), 0);
      check("s6 reset busy", int'(busy), 0);
      check("s6 reset pending", int'(pending), 0);
      check("s6 reset overflow", int'(overflow), 0);
      @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
      for (int r = 0; r <= 40; r++) begin
         tick_in = (r == 5);
         check($sformatf("s6 r%0d level", r), int'(level_out), (r >= 6 && r <= 21) ? 1 : 0);
         check($sformatf("s6 r%0d busy", r), int'(busy), (r >= 6 && r <= 37) ? 1 : 0);
         check($sformatf("s6 r%0d pending", r), int'(pending), 0);
         @(posedge clk_100MHz);
         #1;
      end
      tick_in = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
